ps2_keycode_rx: RTL

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_clk_filter.sv | 57 +++++
 rtl/ps2_keycode_rx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard scan-code receiver.
//   state_t          - receiver FSM state encoding
//   BREAK_CODE       - 0xF0 prefix announcing a key release
//   EXT_CODE         - 0xE0 prefix announcing an extended key
//   frame_parity_ok  - odd-parity check over data byte plus parity bit
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronizes the PS/2 clock and data lines, debounces the
// clock with a FILTER_LEN-deep shift register and flags filtered falling edges.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset (drives everything to idle bus = 1)
//   ps2c, ps2d - raw asynchronous PS/2 clock and data
//   data       - synchronized ps2d
//   fall_edge  - one-cycle strobe on a filtered ps2c 1 -> 0 transition
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic data,
  output logic fall_edge
);

  logic [1:0]            c_sync_r;
  logic [1:0]            d_sync_r;
  logic [FILTER_LEN-1:0] filt_r;
  logic                  fclk_r;
  logic                  fclk_next_s;

  assign data = d_sync_r[1];

  // Filtered clock only moves once the whole window agrees; otherwise it holds.
  always_comb begin
    fclk_next_s = fclk_r;
    if (&filt_r) begin
      fclk_next_s = 1'b1;
    end else if (~|filt_r) begin
      fclk_next_s = 1'b0;
    end else begin
      fclk_next_s = fclk_r;
    end
  end

  // Synchronizers, filter window, filtered clock and edge strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_r  <= 2'b11;
      d_sync_r  <= 2'b11;
      filt_r    <= {FILTER_LEN{1'b1}};
      fclk_r    <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      c_sync_r  <= {c_sync_r[0], ps2c};
      d_sync_r  <= {d_sync_r[0], ps2d};
      filt_r    <= {filt_r[FILTER_LEN-2:0], c_sync_r[1]};
      fclk_r    <= fclk_next_s;
      fall_edge <= fclk_r & ~fclk_next_s;
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: receives PS/2 keyboard frames and reports make codes.
// Break (F0) and extended (E0) prefixes are tracked internally; only make
// codes are emitted, with key_ext flagging an E0-prefixed key.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   ps2c, ps2d  - raw PS/2 clock and data lines
//   key_code    - last accepted make code (held until next key_tick)
//   key_ext     - key_code was E0-prefixed
//   key_tick    - one-cycle strobe: new key_code/key_ext
//   frame_err   - one-cycle strobe: start/parity/stop error or timeout
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_tick,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Firing one count early puts the registered frame_err exactly
  // TIMEOUT_CYCLES after the cycle carrying the last fall_edge.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);

  logic          data_s;
  logic          fall_edge_s;
  logic          timeout_s;
  state_t        state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          par_r;
  logic [TW-1:0] to_cnt_r;
  logic          brk_r;
  logic          ext_r;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .data      (data_s),
    .fall_edge (fall_edge_s)
  );

  // Abort a stalled frame; a fall_edge in the same cycle always wins.
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r != ST_IDLE) && !fall_edge_s && (to_cnt_r == TO_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Frame FSM, prefix tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      to_cnt_r  <= {TW{1'b0}};
      brk_r     <= 1'b0;
      ext_r     <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_tick  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_tick  <= 1'b0;
      frame_err <= 1'b0;
      if (state_r == ST_IDLE || fall_edge_s) begin
        to_cnt_r <= {TW{1'b0}};
      end else begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end

      if (timeout_s) begin
        state_r   <= ST_IDLE;
        frame_err <= 1'b1;
      end else if (fall_edge_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!data_s) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_r   <= {data_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_r   <= data_s;
            state_r <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (data_s && frame_parity_ok(shift_r, par_r)) begin
              if (shift_r == BREAK_CODE) begin
                brk_r <= 1'b1;
              end else if (shift_r == EXT_CODE) begin
                ext_r <= 1'b1;
              end else if (brk_r) begin
                brk_r <= 1'b0;
                ext_r <= 1'b0;
              end else begin
                key_code <= shift_r;
                key_ext  <= ext_r;
                key_tick <= 1'b1;
                ext_r    <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
